// File: rtl/counter_pkg.sv
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared mode and direction encodings for the up/down counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Emits one tick per PRESCALE enabled cycles; clear restarts it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{clk, reset, clear};
      assign tick     = enable;
    end else begin : g_count
      localparam int               c_PCW     = $clog2(PRESCALE);
      localparam logic [c_PCW-1:0] c_PC_LAST = c_PCW'(PRESCALE - 1);

      logic [c_PCW-1:0] r_pc;

      assign tick = enable && (r_pc == c_PC_LAST);

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          r_pc <= '0;
        end else if (enable) begin
          r_pc <= tick ? '0 : r_pc + c_PCW'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mod_up_down_counter.sv
// ============================================================================
// Module   : mod_up_down_counter
// Purpose  : Bounded up/down counter with wrap/saturate, clamped load, prescaler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             reverse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_min
);

  logic             w_tick;
  cnt_dir           w_dir;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf;
  logic             w_unf;
  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .tick   (w_tick)
  );

  assign w_dir = cnt_dir'(reverse);

  // A count above a freshly lowered limit is folded back only on the next step.
  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (load) begin
      w_next = (load_value <= limit) ? load_value : limit;
    end else if (w_tick) begin
      if (w_dir == DIR_UP) begin
        if (r_count < limit) begin
          w_next = r_count + WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
          w_next = '0;
          w_ovf  = 1'b1;
        end else begin
          w_next = limit;
        end
      end else begin
        if (r_count != '0) begin
          w_next = r_count - WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
          w_next = limit;
          w_unf  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end
  end

  assign out    = r_count;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign at_max = (r_count >= limit);
  assign at_min = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_mod_up_down_counter.sv
// ============================================================================
// Module   : tb_mod_up_down_counter
// Purpose  : Vector table plus prescaled sequence checked through expect queues.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_up_down_counter;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rev;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] lim;
    logic        md;
    logic [15:0] e_out;
    logic        e_ovf;
    logic        e_unf;
    logic        e_max;
    logic        e_min;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, enable, reverse, load, mode;
  logic [15:0] load_value, limit;
  logic [15:0] out;
  logic        ovf, unf, at_max, at_min;

  logic        b_reset, b_enable, b_load;
  logic [15:0] b_load_value;
  logic [15:0] b_out;
  logic        b_ovf, b_unf, b_at_max, b_at_min;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  logic [15:0] b_exp_q[$];

  always #5 clk = ~clk;

  mod_up_down_counter #(.WIDTH(16), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .reverse(reverse), .load(load),
    .load_value(load_value), .limit(limit), .mode(mode), .out(out), .ovf(ovf),
    .unf(unf), .at_max(at_max), .at_min(at_min)
  );

  mod_up_down_counter #(.WIDTH(16), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(b_reset), .enable(b_enable), .reverse(1'b0), .load(b_load),
    .load_value(b_load_value), .limit(16'hFFFF), .mode(1'b0), .out(b_out), .ovf(b_ovf),
    .unf(b_unf), .at_max(b_at_max), .at_min(b_at_min)
  );

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, en, rev, ld, input logic [15:0] lv, lim, input logic md,
                     input logic [15:0] e_out, input logic e_ovf, e_unf, e_max, e_min);
    vec_t v;
    v.rst = rst; v.en = en; v.rev = rev; v.ld = ld; v.lv = lv; v.lim = lim; v.md = md;
    v.e_out = e_out; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_max = e_max; v.e_min = e_min;
    vecs.push_back(v);
  endtask

  task automatic step_b(input logic rst, en, ld, input logic [15:0] lv, input logic [15:0] e_out, input int idx);
    logic [15:0] e;
    b_reset = rst; b_enable = en; b_load = ld; b_load_value = lv;
    b_exp_q.push_back(e_out);
    @(posedge clk); #1;
    e = b_exp_q.pop_front();
    chk("p4_out", idx, b_out, e);
    chk("p4_ovf", idx, {15'd0, b_ovf}, 16'd0);
  endtask

  initial begin
    vec_t e;
    reset = 1'b0; enable = 1'b0; reverse = 1'b0; load = 1'b0; mode = 1'b0;
    load_value = '0; limit = 16'hFFFF;
    b_reset = 1'b1; b_enable = 1'b0; b_load = 1'b0; b_load_value = '0;

    // rst en rev ld  lv    lim     md | out   ovf unf max min
    add(0, 0, 0, 1, 16'h1234, 16'hFFFF, 0, 16'h1234, 0, 0, 0, 0);
    add(1, 1, 0, 1, 16'd5,    16'hFFFF, 0, 16'd0,    0, 0, 0, 1);
    for (int k = 1; k <= 9; k++)
      add(0, 1, 0, 0, 16'd0, 16'd9, 0, 16'(k), 0, 0, (k == 9), 0);
    add(0, 1, 0, 0, 16'd0, 16'd9, 0, 16'd0, 1, 0, 0, 1);
    // saturate down from 2
    add(0, 1, 0, 1, 16'd2, 16'd9, 1, 16'd2, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0, 16'd9, 1, 16'd1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 0, 16'd0, 16'd9, 1, 16'd0, 0, 0, 0, 1);
    // wrap down from 2
    add(0, 1, 0, 1, 16'd2, 16'd9, 0, 16'd2, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0, 16'd9, 0, 16'd1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0, 16'd9, 0, 16'd0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 16'd0, 16'd9, 0, 16'd9, 0, 1, 1, 0);
    add(0, 1, 1, 0, 16'd0, 16'd9, 0, 16'd8, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0, 16'd9, 0, 16'd7, 0, 0, 0, 0);
    // load clamp and priority over step
    add(0, 1, 0, 1, 16'd500, 16'd100, 0, 16'd100, 0, 0, 1, 0);
    add(0, 1, 0, 1, 16'd50,  16'd100, 0, 16'd50,  0, 0, 0, 0);
    add(0, 0, 0, 0, 16'd0,   16'd100, 0, 16'd50,  0, 0, 0, 0);
    // limit lowered below the count
    add(0, 0, 0, 0, 16'd0,  16'd20,  0, 16'd50, 0, 0, 1, 0);
    add(0, 1, 0, 0, 16'd0,  16'd20,  0, 16'd0,  1, 0, 0, 1);
    add(0, 0, 0, 1, 16'd50, 16'd100, 1, 16'd50, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd0,  16'd20,  1, 16'd20, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'd50, 16'd100, 0, 16'd50, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0,  16'd20,  0, 16'd49, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'd50, 16'd100, 1, 16'd50, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0,  16'd20,  1, 16'd49, 0, 0, 1, 0);
    // limit = 0
    add(0, 1, 0, 0, 16'd0, 16'd0, 0, 16'd0, 1, 0, 1, 1);
    add(0, 1, 1, 0, 16'd0, 16'd0, 0, 16'd0, 0, 1, 1, 1);
    add(0, 1, 0, 0, 16'd0, 16'd0, 1, 16'd0, 0, 0, 1, 1);
    // reverse toggled every step, mid-count reset, idle hold
    add(0, 1, 0, 0, 16'd0, 16'd9, 0, 16'd1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd0, 16'd9, 0, 16'd0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 16'd0, 16'd9, 0, 16'd1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd0, 16'd9, 0, 16'd2, 0, 0, 0, 0);
    add(1, 1, 0, 1, 16'd7, 16'd9, 0, 16'd0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 16'd0, 16'd9, 0, 16'd0, 0, 0, 0, 1);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en; reverse = vecs[i].rev; load = vecs[i].ld;
      load_value = vecs[i].lv; limit = vecs[i].lim; mode = vecs[i].md;
      exp_q.push_back(vecs[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("out",    i, out,               e.e_out);
      chk("ovf",    i, {15'd0, ovf},      {15'd0, e.e_ovf});
      chk("unf",    i, {15'd0, unf},      {15'd0, e.e_unf});
      chk("at_max", i, {15'd0, at_max},   {15'd0, e.e_max});
      chk("at_min", i, {15'd0, at_min},   {15'd0, e.e_min});
    end

    // Prescale of 4: steps after the 4th and 8th enabled cycles.
    step_b(1, 0, 0, 16'd0, 16'd0, 0);
    step_b(0, 1, 0, 16'd0, 16'd0, 1);
    step_b(0, 1, 0, 16'd0, 16'd0, 2);
    step_b(0, 0, 0, 16'd0, 16'd0, 3);
    step_b(0, 1, 0, 16'd0, 16'd0, 4);
    step_b(0, 1, 0, 16'd0, 16'd1, 5);
    step_b(0, 1, 0, 16'd0, 16'd1, 6);
    step_b(0, 1, 0, 16'd0, 16'd1, 7);
    step_b(0, 1, 0, 16'd0, 16'd1, 8);
    step_b(0, 1, 0, 16'd0, 16'd2, 9);
    // load part-way through a count restarts the group of four
    step_b(0, 1, 0, 16'd0,  16'd2,  10);
    step_b(0, 1, 0, 16'd0,  16'd2,  11);
    step_b(0, 1, 1, 16'd10, 16'd10, 12);
    step_b(0, 1, 0, 16'd0,  16'd10, 13);
    step_b(0, 1, 0, 16'd0,  16'd10, 14);
    step_b(0, 1, 0, 16'd0,  16'd10, 15);
    step_b(0, 1, 0, 16'd0,  16'd11, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
